// File: rtl/rnbip_pkg.sv
// Shared encodings for the RNBIP-2 datapath: opcodes, regfile controls, ALU ops
// and the sequencer state type.
package rnbip_pkg;

  localparam logic [3:0] OP_NOP    = 4'h0;
  localparam logic [3:0] OP_MOV_RN = 4'h1;
  localparam logic [3:0] OP_MOV_R0 = 4'h2;
  localparam logic [3:0] OP_MVI    = 4'h3;
  localparam logic [3:0] OP_ADD    = 4'h4;
  localparam logic [3:0] OP_SUB    = 4'h5;
  localparam logic [3:0] OP_AND    = 4'h6;
  localparam logic [3:0] OP_OR     = 4'h7;
  localparam logic [3:0] OP_XOR    = 4'h8;
  localparam logic [3:0] OP_JMP    = 4'h9;
  localparam logic [3:0] OP_CLR    = 4'hE;
  localparam logic [3:0] OP_HLT    = 4'hF;

  localparam logic [1:0] ENAB_CLR  = 2'b00;
  localparam logic [1:0] ENAB_WR   = 2'b01;
  localparam logic [1:0] ENAB_IDLE = 2'b10;
  localparam logic [1:0] ENAB_RD   = 2'b11;

  localparam logic [2:0] MUX_R0  = 3'b000;
  localparam logic [2:0] MUX_RN  = 3'b001;
  localparam logic [2:0] MUX_OR2 = 3'b010;
  localparam logic [2:0] MUX_ALU = 3'b011;

  localparam logic [2:0] ALU_ADD = 3'b000;
  localparam logic [2:0] ALU_SUB = 3'b001;
  localparam logic [2:0] ALU_AND = 3'b010;
  localparam logic [2:0] ALU_OR  = 3'b011;
  localparam logic [2:0] ALU_XOR = 3'b100;

  typedef enum logic [3:0] {
    ST_INIT,
    ST_FETCH1,
    ST_DECODE,
    ST_FETCH2,
    ST_EXEC,
    ST_READ,
    ST_ALU_WAIT,
    ST_WB,
    ST_HALT
  } state_t;

endpackage

// File: rtl/rnbip_decode.sv
// Combinational opcode classifier: instruction length, ALU class/op and legality.
module rnbip_decode
  import rnbip_pkg::*;
#(
  parameter int unsigned ALU_OP_W = 3
) (
  input  logic [3:0]          opcode,
  output logic                two_byte,
  output logic                is_alu,
  output logic [ALU_OP_W-1:0] alu_op,
  output logic                legal
);

  always_comb begin
    two_byte = 1'b0;
    is_alu   = 1'b0;
    alu_op   = '0;
    legal    = 1'b1;
    case (opcode)
      OP_MVI, OP_JMP: two_byte = 1'b1;
      OP_ADD: begin is_alu = 1'b1; alu_op = ALU_OP_W'(ALU_ADD); end
      OP_SUB: begin is_alu = 1'b1; alu_op = ALU_OP_W'(ALU_SUB); end
      OP_AND: begin is_alu = 1'b1; alu_op = ALU_OP_W'(ALU_AND); end
      OP_OR:  begin is_alu = 1'b1; alu_op = ALU_OP_W'(ALU_OR);  end
      OP_XOR: begin is_alu = 1'b1; alu_op = ALU_OP_W'(ALU_XOR); end
      OP_NOP, OP_MOV_RN, OP_MOV_R0, OP_CLR, OP_HLT: ;
      default: legal = 1'b0;
    endcase
  end

endmodule

// File: rtl/rnbip_ctrl_seq.sv
// RNBIP-2 fetch/decode/execute sequencer: program-memory fetch, PC and OR2
// registers, register-file control and ALU start/done handshake.
module rnbip_ctrl_seq
  import rnbip_pkg::*;
#(
  parameter int unsigned     PC_W     = 8,
  parameter logic [PC_W-1:0] RESET_PC = 8'h00,
  parameter int unsigned     ALU_OP_W = 3
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic [7:0]          imem_rdata,
  input  logic                imem_ack,
  input  logic                alu_done,
  output logic [PC_W-1:0]     imem_addr,
  output logic                imem_req,
  output logic [7:0]          or2,
  output logic [1:0]          enab,
  output logic [2:0]          mux_sel,
  output logic [2:0]          reg_sel,
  output logic [2:0]          seg,
  output logic [ALU_OP_W-1:0] alu_op,
  output logic                alu_start,
  output logic                halted,
  output logic                illegal
);

  state_t              state_q, state_d;
  logic [PC_W-1:0]     pc_q;
  logic [3:0]          opcode_q;
  logic [2:0]          n_q;
  logic [7:0]          or2_q;
  logic                dec_two_byte, dec_is_alu, dec_legal;
  logic [ALU_OP_W-1:0] dec_alu_op;

  rnbip_decode #(.ALU_OP_W(ALU_OP_W)) u_decode (
    .opcode   (opcode_q),
    .two_byte (dec_two_byte),
    .is_alu   (dec_is_alu),
    .alu_op   (dec_alu_op),
    .legal    (dec_legal)
  );

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q  <= ST_INIT;
      pc_q     <= RESET_PC;
      opcode_q <= '0;
      n_q      <= '0;
      or2_q    <= '0;
    end else begin
      state_q <= state_d;
      case (state_q)
        ST_FETCH1: if (imem_ack) begin
          opcode_q <= imem_rdata[7:4];
          n_q      <= imem_rdata[2:0];
          pc_q     <= pc_q + PC_W'(1);
        end
        ST_FETCH2: if (imem_ack) begin
          or2_q <= imem_rdata;
          pc_q  <= (opcode_q == OP_JMP) ? PC_W'(imem_rdata) : pc_q + PC_W'(1);
        end
        default: ;
      endcase
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_INIT:     state_d = ST_FETCH1;
      ST_FETCH1:   if (imem_ack) state_d = ST_DECODE;
      ST_DECODE: begin
        if (dec_two_byte)            state_d = ST_FETCH2;
        else if (dec_is_alu)         state_d = ST_READ;
        else if (opcode_q == OP_HLT) state_d = ST_HALT;
        else                         state_d = ST_EXEC;
      end
      ST_FETCH2:   if (imem_ack) state_d = (opcode_q == OP_JMP) ? ST_FETCH1 : ST_EXEC;
      ST_EXEC:     state_d = ST_FETCH1;
      ST_READ:     state_d = ST_ALU_WAIT;
      ST_ALU_WAIT: if (alu_done) state_d = ST_WB;
      ST_WB:       state_d = ST_FETCH1;
      ST_HALT:     state_d = ST_HALT;
      default:     state_d = ST_INIT;
    endcase
  end

  always_comb begin
    enab      = ENAB_IDLE;
    mux_sel   = MUX_R0;
    reg_sel   = '0;
    seg       = '0;
    alu_op    = '0;
    alu_start = 1'b0;
    imem_req  = 1'b0;
    halted    = 1'b0;
    illegal   = 1'b0;
    case (state_q)
      // INIT is held while in reset; the clear shows only in the release cycle.
      ST_INIT:   enab = rst_n ? ENAB_CLR : ENAB_IDLE;
      ST_FETCH1,
      ST_FETCH2: imem_req = 1'b1;
      ST_DECODE: illegal = ~dec_legal;
      ST_EXEC: begin
        case (opcode_q)
          OP_MOV_RN: begin enab = ENAB_WR; seg = n_q; mux_sel = MUX_R0; end
          OP_MOV_R0: begin enab = ENAB_WR; mux_sel = MUX_RN; reg_sel = n_q; end
          OP_MVI:    begin enab = ENAB_WR; seg = n_q; mux_sel = MUX_OR2; end
          OP_CLR:    enab = ENAB_CLR;
          default: ;
        endcase
      end
      ST_READ: begin
        enab      = ENAB_RD;
        seg       = n_q;
        alu_op    = dec_alu_op;
        alu_start = 1'b1;
      end
      ST_WB: begin
        enab    = ENAB_WR;
        mux_sel = MUX_ALU;
      end
      ST_HALT: halted = 1'b1;
      default: ;
    endcase
  end

  assign imem_addr = pc_q;
  assign or2       = or2_q;

endmodule

// File: tb/tb_rnbip_ctrl_seq.sv
// Self-checking bench for rnbip_ctrl_seq: an instruction-level ISA model predicts
// the stream of fetches and regfile/ALU operations, compared against a monitor.
module tb_rnbip_ctrl_seq;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [7:0] imem_rdata = 8'h00;
  logic       imem_ack = 1'b0;
  logic       alu_done = 1'b0;
  logic [7:0] imem_addr;
  logic       imem_req;
  logic [7:0] or2;
  logic [1:0] enab;
  logic [2:0] mux_sel, reg_sel, seg, alu_op;
  logic       alu_start, halted, illegal;

  always #5 clk = ~clk;

  rnbip_ctrl_seq #(.PC_W(8), .RESET_PC(8'h00), .ALU_OP_W(3)) dut (
    .clk(clk), .rst_n(rst_n), .imem_rdata(imem_rdata), .imem_ack(imem_ack),
    .alu_done(alu_done), .imem_addr(imem_addr), .imem_req(imem_req), .or2(or2),
    .enab(enab), .mux_sel(mux_sel), .reg_sel(reg_sel), .seg(seg), .alu_op(alu_op),
    .alu_start(alu_start), .halted(halted), .illegal(illegal)
  );

  logic [7:0]  mem [256];
  logic [31:0] exp_q[$];
  logic [31:0] mon_q[$];
  int          fcyc[$];
  int          ccyc;
  int          cyc = 0;
  bit          exp_halt;
  bit          mon_en = 0, ack_zero = 0, alu_hold = 0, force_done = 0, req_busy = 0;
  int          alu_lat = 0, wait_left = 0, alu_cnt = 0;
  int          checks = 0, failures = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%h expected=%h", tag, got, exp);
    end
  endtask

  // kinds: 1 fetch, 2 write, 3 clear, 4 read/start, 5 illegal, 6 stray start
  function automatic logic [31:0] ev(input logic [3:0] kind, input logic [2:0] mux,
                                     input logic [2:0] rs, input logic [2:0] sg,
                                     input logic [7:0] data);
    return {kind, 1'b0, mux, 1'b0, rs, 1'b0, sg, 8'h00, data};
  endfunction

  // Memory responder, ALU responder and event monitor share one sampling point.
  always @(negedge clk) begin
    if (imem_req) begin
      if (!req_busy) begin
        req_busy  = 1;
        wait_left = ack_zero ? 0 : $urandom_range(0, 2);
      end
      if (wait_left == 0) begin
        imem_ack   = 1'b1;
        imem_rdata = mem[imem_addr];
        req_busy   = 0;
      end else begin
        imem_ack = 1'b0;
        wait_left--;
      end
    end else begin
      imem_ack = 1'b0;
      req_busy = 0;
    end

    alu_done = 1'b0;
    if (!rst_n) alu_cnt = 0;
    if (alu_cnt > 0) begin
      alu_cnt--;
      if (alu_cnt == 0 && !alu_hold) alu_done = 1'b1;
    end
    if (alu_start) begin
      alu_cnt  = (alu_lat != 0) ? alu_lat : $urandom_range(1, 3);
      alu_done = 1'($urandom_range(0, 1));
    end
    if (force_done) alu_done = 1'b1;

    if (mon_en && rst_n) begin
      if (imem_req && imem_ack) begin
        mon_q.push_back(ev(4'h1, 3'd0, 3'd0, 3'd0, imem_addr));
        fcyc.push_back(cyc);
      end
      case (enab)
        2'b01: mon_q.push_back(ev(4'h2, mux_sel, (mux_sel == 3'b001) ? reg_sel : 3'd0, seg,
                                  (mux_sel == 3'b010) ? or2 : 8'h00));
        2'b00: begin mon_q.push_back(ev(4'h3, 3'd0, 3'd0, 3'd0, 8'h00)); ccyc = cyc; end
        2'b11: mon_q.push_back(ev(4'h4, alu_op, 3'd0, seg, {7'd0, alu_start}));
        default: ;
      endcase
      if (alu_start && enab != 2'b11) mon_q.push_back(ev(4'h6, 3'd0, 3'd0, 3'd0, 8'h00));
      if (illegal) mon_q.push_back(ev(4'h5, 3'd0, 3'd0, 3'd0, 8'h00));
    end
    cyc++;
  end

  // ISA-level model: walks the program and lists the visible operations in order.
  function automatic void build(input int max_instr);
    logic [7:0] pc, b0, imm;
    logic [3:0] op;
    logic [2:0] n;
    exp_q.delete();
    exp_halt = 0;
    pc = 8'h00;
    exp_q.push_back(ev(4'h3, 3'd0, 3'd0, 3'd0, 8'h00));
    for (int k = 0; k < max_instr; k++) begin
      b0 = mem[pc];
      exp_q.push_back(ev(4'h1, 3'd0, 3'd0, 3'd0, pc));
      pc = pc + 8'd1;
      op = b0[7:4];
      n  = b0[2:0];
      if (op == 4'h3 || op == 4'h9) begin
        exp_q.push_back(ev(4'h1, 3'd0, 3'd0, 3'd0, pc));
        imm = mem[pc];
        pc  = pc + 8'd1;
        if (op == 4'h9) pc = imm;
        else exp_q.push_back(ev(4'h2, 3'b010, 3'd0, n, imm));
      end else if (op == 4'h1) begin
        exp_q.push_back(ev(4'h2, 3'b000, 3'd0, n, 8'h00));
      end else if (op == 4'h2) begin
        exp_q.push_back(ev(4'h2, 3'b001, n, 3'd0, 8'h00));
      end else if (op >= 4'h4 && op <= 4'h8) begin
        exp_q.push_back(ev(4'h4, 3'(op - 4'h4), 3'd0, n, 8'h01));
        exp_q.push_back(ev(4'h2, 3'b011, 3'd0, 3'd0, 8'h00));
      end else if (op == 4'hF) begin
        exp_halt = 1;
        return;
      end else if (op == 4'hE) begin
        exp_q.push_back(ev(4'h3, 3'd0, 3'd0, 3'd0, 8'h00));
      end else if (op != 4'h0) begin
        exp_q.push_back(ev(4'h5, 3'd0, 3'd0, 3'd0, 8'h00));
      end
    end
  endfunction

  task automatic reset_dut();
    @(posedge clk); #1;
    rst_n  = 1'b0;
    mon_en = 0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_enab", enab, 2'b10);
    chk("rst_req", imem_req, 1'b0);
    chk("rst_addr", imem_addr, 8'h00);
    chk("rst_or2", or2, 8'h00);
    chk("rst_misc", {halted, alu_start, illegal, mux_sel, reg_sel, seg, alu_op}, '0);
    mon_q.delete();
    fcyc.delete();
    mon_en = 1;
    rst_n  = 1'b1;
  endtask

  task automatic fill(input logic [7:0] b);
    for (int i = 0; i < 256; i++) mem[i] = b;
  endtask

  task automatic run_prog(input string tag, input int max_instr, input int max_cyc);
    bit timed_out;
    logic [31:0] got;
    build(max_instr);
    reset_dut();
    timed_out = 1;
    for (int c = 0; c < max_cyc; c++) begin
      @(posedge clk); #1;
      if (exp_halt ? (halted == 1'b1) : (mon_q.size() >= exp_q.size())) begin
        timed_out = 0;
        break;
      end
    end
    @(negedge clk); #1;
    chk({tag, "_timeout"}, timed_out, 1'b0);
    for (int i = 0; i < exp_q.size(); i++) begin
      got = (i < mon_q.size()) ? mon_q[i] : 32'hDEAD_DEAD;
      chk($sformatf("%s_ev%0d", tag, i), got, exp_q[i]);
    end
    if (exp_halt) chk({tag, "_halted"}, halted, 1'b1);
  endtask

  initial begin
    int cnt;
    bit seen;

    // NOP stream with zero-wait memory: one clear cycle, then 3 cycles per NOP.
    fill(8'h00);
    ack_zero = 1;
    run_prog("nop", 5, 200);
    chk("nop_first_fetch", (fcyc.size() > 0) ? fcyc[0] - ccyc : -1, 1);
    for (int i = 1; i < 5; i++)
      chk($sformatf("nop_period%0d", i), (fcyc.size() > i) ? fcyc[i] - fcyc[i-1] : -1, 3);

    fill(8'hF0);
    mem[0] = 8'h33; mem[1] = 8'h5A;
    run_prog("mvi", 10, 200);
    chk("mvi_or2", or2, 8'h5A);

    fill(8'hF0);
    mem[0] = 8'h42;
    alu_lat = 2;
    run_prog("alu", 10, 200);
    alu_lat = 0;

    fill(8'hF0);
    mem[0] = 8'h90; mem[1] = 8'hFE; mem[8'hFE] = 8'h90; mem[8'hFF] = 8'h90;
    run_prog("jmp_fe", 10, 200);
    mem[1] = 8'hFF;
    run_prog("jmp_ff", 10, 200);

    ack_zero = 0;
    for (int r = 0; r < 6; r++) begin
      for (int i = 0; i < 256; i++) mem[i] = 8'($urandom);
      run_prog($sformatf("rnd%0d", r), 40, 3000);
    end

    // Illegal opcode then HLT: processor must stay parked.
    fill(8'hF0);
    mem[0] = 8'hA0;
    ack_zero = 1;
    run_prog("ill", 10, 200);
    cnt = 0;
    repeat (20) begin
      @(posedge clk); #1;
      if (imem_req || !halted || enab != 2'b10) cnt++;
    end
    chk("halt_parked", cnt, 0);

    // Reset while waiting on the ALU, with a late done: no writeback follows.
    fill(8'hF0);
    mem[0] = 8'h00; mem[1] = 8'h42;
    alu_hold = 1;
    reset_dut();
    seen = 0;
    for (int c = 0; c < 50; c++) begin
      @(posedge clk); #1;
      if (alu_start) begin seen = 1; break; end
    end
    chk("abort_start_seen", seen, 1'b1);
    @(posedge clk); #1;
    chk("abort_wait_idle", enab, 2'b10);
    @(posedge clk); #1;
    rst_n = 1'b0;
    @(posedge clk); #1;
    chk("abort_rst_enab", enab, 2'b10);
    chk("abort_rst_pc", imem_addr, 8'h00);
    force_done = 1;
    rst_n = 1'b1;
    #1;
    chk("abort_init_clear", enab, 2'b00);
    @(posedge clk); #1;
    chk("abort_fetch", {imem_req, enab, imem_addr}, {1'b1, 2'b10, 8'h00});
    @(posedge clk); #1;
    force_done = 0;
    cnt = 0;
    repeat (4) begin
      @(posedge clk); #1;
      if (enab == 2'b01) cnt++;
    end
    chk("abort_no_wb", cnt, 0);
    alu_hold = 0;

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
